// File: rtl/ldo_find_pipe.sv
// Count-leading-zeros stage: log2 leading-one tree over a word padded to a power of two.
// Define LDO_PIPE_EN to register the tree midway (latency 2 instead of 1).
module ldo_find_pipe #(
    parameter int DATA_W = 32,
    parameter int POS_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    output logic [POS_W-1:0]  pos_out
);

    localparam int LOG   = $clog2(DATA_W);
    localparam int PAD_W = 1 << LOG;
    localparam int SPLIT = (LOG + 1) / 2;
    localparam int NS    = PAD_W >> SPLIT;
    localparam int MID_W = NS * (LOG + 1);

    typedef logic [LOG-1:0] cnt_t;

    // Lower tree levels: returns per-node {valid, count} packed at level SPLIT
    function automatic logic [MID_W-1:0] merge_lower(input logic [PAD_W-1:0] word);
        logic [PAD_W-1:0] v;
        cnt_t             c [PAD_W];
        logic [MID_W-1:0] res;
        v = word;
        for (int i = 0; i < PAD_W; i++) c[i] = '0;
        // In-place merge is safe: node j only reads nodes 2j and 2j+1
        for (int l = 1; l <= SPLIT; l++) begin
            for (int j = 0; j < (PAD_W >> l); j++) begin
                if (v[2*j+1]) c[j] = c[2*j+1];
                else          c[j] = (cnt_t'(1'b1) << (l - 1)) | c[2*j];
                v[j] = v[2*j+1] | v[2*j];
            end
        end
        res = '0;
        for (int j = 0; j < NS; j++) res[j*(LOG+1) +: (LOG+1)] = {v[j], c[j]};
        return res;
    endfunction

    // Upper tree levels and all-zero clamp to DATA_W
    function automatic logic [POS_W-1:0] merge_upper(input logic [MID_W-1:0] mid);
        logic [NS-1:0] v;
        cnt_t          c [NS];
        for (int j = 0; j < NS; j++) begin
            v[j] = mid[j*(LOG+1) + LOG];
            c[j] = mid[j*(LOG+1) +: LOG];
        end
        for (int l = SPLIT + 1; l <= LOG; l++) begin
            for (int j = 0; j < (PAD_W >> l); j++) begin
                if (v[2*j+1]) c[j] = c[2*j+1];
                else          c[j] = (cnt_t'(1'b1) << (l - 1)) | c[2*j];
                v[j] = v[2*j+1] | v[2*j];
            end
        end
        if (v[0]) return POS_W'(c[0]);
        else      return POS_W'(DATA_W);
    endfunction

    logic [PAD_W-1:0] pad_s;

    // Pad bits go below the LSB so they never affect the leading-zero count
    assign pad_s = PAD_W'(data_in) << (PAD_W - DATA_W);

`ifdef LDO_PIPE_EN
    logic             s1_valid_r;
    logic [MID_W-1:0] mid_r;

    // Stage 1: lower half of the merge tree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            mid_r      <= '0;
        end else begin
            s1_valid_r <= in_valid;
            if (in_valid) mid_r <= merge_lower(pad_s);
        end
    end

    // Stage 2: upper half of the tree into the held output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            pos_out   <= '0;
        end else begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) pos_out <= merge_upper(mid_r);
        end
    end
`else
    // Single stage: whole tree into the held output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            pos_out   <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) pos_out <= merge_upper(merge_lower(pad_s));
        end
    end
`endif

endmodule

// File: tb/tb_ldo_find_pipe.sv
// Directed bench for ldo_find_pipe with a per-cycle expected-result queue.
// Honours LDO_PIPE_EN to select the expected latency.
module tb_ldo_find_pipe;

`ifdef LDO_PIPE_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    typedef struct packed {
        logic       v;
        logic [5:0] pos;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] data_in;
    logic        out_valid;
    logic [5:0]  pos_out;

    exp_t        sb_q[$];
    logic [5:0]  last_pos;
    int          vectors;
    int          miscompares;

    ldo_find_pipe #(.DATA_W(32), .POS_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .out_valid (out_valid),
        .pos_out   (pos_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference count: scan down from the MSB
    function automatic logic [5:0] clz_ref(input logic [31:0] d);
        for (int i = 31; i >= 0; i--) begin
            if (d[i]) return 6'(31 - i);
        end
        return 6'd32;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic prefill();
        sb_q.delete();
        for (int i = 0; i < L - 1; i++) sb_q.push_back(exp_t'{v: 1'b0, pos: 6'd0});
    endtask

    task automatic step(input logic v, input logic [31:0] d, input string tag);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        data_in  = d;
        sb_q.push_back(exp_t'{v: v, pos: (v ? clz_ref(d) : 6'd0)});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, e.v});
        if (e.v) begin
            last_pos = e.pos;
            check({tag, ".pos"}, {26'd0, pos_out}, {26'd0, e.pos});
        end else begin
            check({tag, ".hold"}, {26'd0, pos_out}, {26'd0, last_pos});
        end
    endtask

    initial begin
        logic [31:0] w;
        vectors     = 0;
        miscompares = 0;
        last_pos    = 6'd0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        data_in     = 32'd0;
        #12;
        check("reset.valid", {31'd0, out_valid}, 32'd0);
        check("reset.pos", {26'd0, pos_out}, 32'd0);
        rst_n = 1'b1;
        prefill();

        step(1'b1, 32'h0000_0000, "zero");
        step(1'b1, 32'h1880_0000, "s0");
        step(1'b1, 32'h00FF_000D, "s1");
        step(1'b1, 32'h0000_000A, "s2");
        for (int i = 31; i >= 0; i--) begin
            w = 32'd1 << i;
            step(1'b1, w, "walk");
        end
        step(1'b1, 32'hFFFF_FFFF, "ones");
        for (int i = 0; i < L; i++) step(1'b0, 32'hDEAD_0000, "drain");

        step(1'b1, 32'h0000_000A, "pulse");
        for (int i = 0; i < 4; i++) step(1'b0, $urandom | 32'h8000_0000, "idle");
        check("hold28", {26'd0, pos_out}, 32'd28);

        step(1'b1, 32'h0000_4000, "pre_rst0");
        step(1'b1, 32'h0100_0000, "pre_rst1");
        in_valid = 1'b1;
        data_in  = 32'h0000_0100;
        #3;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("async.valid", {31'd0, out_valid}, 32'd0);
        check("async.pos", {26'd0, pos_out}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n    = 1'b1;
        last_pos = 6'd0;
        prefill();
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0000_0000, "post_rst_idle");
        step(1'b1, 32'h0004_0000, "post_rst");
        for (int i = 0; i < L; i++) step(1'b0, 32'h0000_0000, "tail");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
